// File: rtl/ltc2324_16_capture.sv
`default_nettype none
// ============================================================================
// Module   : ltc2324_16_capture
// Purpose  : LTC2324-16 conversion/readout controller. Sequences CNV and SCK
//            and deserialises SDO1..SDO4 on internal SCK timing or CLKOUT.
// Revision : 1.0 - initial release
// ============================================================================
module ltc2324_16_capture #(
    parameter logic USE_SCK_SHIFT_DATA = 1'b0,
    parameter int   CNV_HIGH_CYC       = 2,
    parameter int   CONV_WAIT_CYC      = 45,
    parameter int   SCK_HALF           = 2,
    parameter int   CLKOUT_TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        CNV,
    output logic        SCK,
    input  logic        CLKOUT,
    input  logic        SDO1,
    input  logic        SDO2,
    input  logic        SDO3,
    input  logic        SDO4,
    input  logic        sample_en,
    output logic        valid,
    output logic [15:0] ch1,
    output logic [15:0] ch2,
    output logic [15:0] ch3,
    output logic [15:0] ch4,
    output logic        frame_err
);

    localparam logic [15:0] CNV_LAST   = 16'(CNV_HIGH_CYC - 1);
    localparam logic [15:0] WAIT_LAST  = 16'(CONV_WAIT_CYC - 1);
    localparam logic [15:0] SHIFT_LAST = 16'(32 * SCK_HALF - 1);
    localparam logic [15:0] TAIL_LAST  = 16'd2;
    localparam logic [15:0] TOUT_LAST  = 16'(CLKOUT_TIMEOUT - 1);
    localparam logic [15:0] HALF_LAST  = 16'(SCK_HALF - 1);
    localparam logic [4:0]  BITS       = 5'd16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CNV   = 3'd1,
        S_WAIT  = 3'd2,
        S_SHIFT = 3'd3,
        S_TAIL  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] cnt;
    logic [15:0] cnt_next;
    logic [15:0] half_cnt;
    logic [15:0] half_next;
    logic        sck_next;
    logic        timeout;

    // Bit 4 carries CLKOUT, bits 3..0 carry SDO4..SDO1
    logic [4:0]  sync1;
    logic [4:0]  sync2;
    logic        clkout_prev;
    logic        sck_prev;
    logic        sck_fall_d;
    logic        clkout_fall;
    logic        sck_fall;
    logic        in_capture;
    logic        cap_fire;
    logic        frame_start;
    logic [4:0]  cap_cnt;
    logic [15:0] sr1;
    logic [15:0] sr2;
    logic [15:0] sr3;
    logic [15:0] sr4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {CLKOUT, SDO4, SDO3, SDO2, SDO1};
            sync2 <= sync1;
        end
    end

    always_comb begin
        next_state = state;
        timeout    = 1'b0;
        case (state)
            S_IDLE:  if (sample_en) next_state = S_CNV;
            S_CNV:   if (cnt == CNV_LAST) next_state = S_WAIT;
            S_WAIT:  if (cnt == WAIT_LAST) next_state = S_SHIFT;
            S_SHIFT: if (cnt == SHIFT_LAST) next_state = S_TAIL;
            S_TAIL: begin
                if (USE_SCK_SHIFT_DATA) begin
                    if (cnt == TAIL_LAST) next_state = S_DONE;
                end else if (cap_cnt == BITS) begin
                    next_state = S_DONE;
                end else if (cnt == TOUT_LAST) begin
                    next_state = S_IDLE;
                    timeout    = 1'b1;
                end
            end
            S_DONE:  next_state = sample_en ? S_CNV : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_next = cnt + 16'd1;
        if (state == S_IDLE || next_state != state) cnt_next = '0;
    end

    // SCK starts high on SHIFT entry and toggles every SCK_HALF cycles
    always_comb begin
        sck_next  = 1'b0;
        half_next = '0;
        if (next_state == S_SHIFT) begin
            if (state != S_SHIFT) begin
                sck_next = 1'b1;
            end else if (half_cnt == HALF_LAST) begin
                sck_next = ~SCK;
            end else begin
                sck_next  = SCK;
                half_next = half_cnt + 16'd1;
            end
        end
    end

    assign clkout_fall = clkout_prev & ~sync2[4];
    assign sck_fall    = sck_prev & ~SCK;
    assign in_capture  = (state == S_SHIFT) || (state == S_TAIL);
    assign cap_fire    = in_capture && (cap_cnt != BITS) &&
                         (USE_SCK_SHIFT_DATA ? sck_fall_d : clkout_fall);
    assign frame_start = (next_state == S_CNV) && (state != S_CNV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            half_cnt    <= '0;
            CNV         <= 1'b0;
            SCK         <= 1'b0;
            valid       <= 1'b0;
            frame_err   <= 1'b0;
            sck_prev    <= 1'b0;
            sck_fall_d  <= 1'b0;
            clkout_prev <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= cnt_next;
            half_cnt    <= half_next;
            CNV         <= (next_state == S_CNV);
            SCK         <= sck_next;
            valid       <= (state == S_DONE);
            frame_err   <= timeout;
            sck_prev    <= SCK;
            sck_fall_d  <= sck_fall;
            clkout_prev <= sync2[4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_cnt <= '0;
            sr1     <= '0;
            sr2     <= '0;
            sr3     <= '0;
            sr4     <= '0;
            ch1     <= '0;
            ch2     <= '0;
            ch3     <= '0;
            ch4     <= '0;
        end else begin
            if (frame_start) begin
                cap_cnt <= '0;
                sr1     <= '0;
                sr2     <= '0;
                sr3     <= '0;
                sr4     <= '0;
            end else if (cap_fire) begin
                cap_cnt <= cap_cnt + 5'd1;
                sr1     <= {sr1[14:0], sync2[0]};
                sr2     <= {sr2[14:0], sync2[1]};
                sr3     <= {sr3[14:0], sync2[2]};
                sr4     <= {sr4[14:0], sync2[3]};
            end
            if (state == S_DONE) begin
                ch1 <= sr1;
                ch2 <= sr2;
                ch3 <= sr3;
                ch4 <= sr4;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ltc2324_16_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_ltc2324_16_capture
// Purpose  : Scoreboard bench; instance a captures on internal SCK timing,
//            instance b on CLKOUT. Each has its own ADC model and monitor.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ltc2324_16_capture;

    typedef struct {
        bit          err;
        logic [63:0] data;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        a_rst_n = 1'b0, a_en = 1'b0;
    logic        a_cnv, a_sck, a_valid, a_err;
    logic [15:0] a_ch1, a_ch2, a_ch3, a_ch4;
    logic [3:0]  a_sdo_m = '0, noise_a = '0;
    logic [3:0]  a_sdo;
    logic [63:0] a_chv;
    assign a_sdo = a_sdo_m ^ noise_a;
    assign a_chv = {a_ch1, a_ch2, a_ch3, a_ch4};

    logic        b_rst_n = 1'b0, b_en = 1'b0;
    logic        b_cnv, b_sck, b_valid, b_err;
    logic [15:0] b_ch1, b_ch2, b_ch3, b_ch4;
    logic [3:0]  b_sdo_m = '0, noise_b = '0;
    logic [3:0]  b_sdo;
    logic        noise_ck = 1'b0;
    logic        b_clkout;
    logic [63:0] b_chv;
    logic [2:0]  b_ckd = '0;
    int          b_falls = 0;
    int          b_stop_after = 1000;
    assign b_sdo    = b_sdo_m ^ noise_b;
    assign b_chv    = {b_ch1, b_ch2, b_ch3, b_ch4};
    assign b_clkout = (b_ckd[2] & (b_falls < b_stop_after)) ^ noise_ck;

    ltc2324_16_capture #(.USE_SCK_SHIFT_DATA(1'b1)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .CNV(a_cnv), .SCK(a_sck), .CLKOUT(1'b0),
        .SDO1(a_sdo[0]), .SDO2(a_sdo[1]), .SDO3(a_sdo[2]), .SDO4(a_sdo[3]),
        .sample_en(a_en), .valid(a_valid),
        .ch1(a_ch1), .ch2(a_ch2), .ch3(a_ch3), .ch4(a_ch4), .frame_err(a_err)
    );

    ltc2324_16_capture dut_b (
        .clk(clk), .rst_n(b_rst_n), .CNV(b_cnv), .SCK(b_sck), .CLKOUT(b_clkout),
        .SDO1(b_sdo[0]), .SDO2(b_sdo[1]), .SDO3(b_sdo[2]), .SDO4(b_sdo[3]),
        .sample_en(b_en), .valid(b_valid),
        .ch1(b_ch1), .ch2(b_ch2), .ch3(b_ch3), .ch4(b_ch4), .frame_err(b_err)
    );

    // ADC models: word {ch1,ch2,ch3,ch4} loaded on CNV, MSB-first on each rise
    logic [63:0] a_mq[$], b_mq[$];
    logic [63:0] a_word = '0, b_word = '0;
    int          a_bit = -1, b_bit = -1;

    always @(posedge a_cnv or posedge a_sck) begin
        if (a_sck) begin
            #1;
            if (a_bit >= 0) begin
                a_sdo_m = {a_word[a_bit], a_word[16 + a_bit], a_word[32 + a_bit], a_word[48 + a_bit]};
                a_bit--;
            end
        end else begin
            a_word = (a_mq.size() != 0) ? a_mq.pop_front() : 64'h0;
            a_bit  = 15;
        end
    end

    always @(posedge b_cnv or posedge b_clkout) begin
        if (b_clkout) begin
            #1;
            if (b_bit >= 0) begin
                b_sdo_m = {b_word[b_bit], b_word[16 + b_bit], b_word[32 + b_bit], b_word[48 + b_bit]};
                b_bit--;
            end
        end else begin
            b_word = (b_mq.size() != 0) ? b_mq.pop_front() : 64'h0;
            b_bit  = 15;
        end
    end

    // CLKOUT is SCK delayed three clocks, cut off after b_stop_after falling edges
    always @(posedge clk) begin
        b_ckd <= {b_ckd[1:0], b_sck};
        if (b_cnv) b_falls <= 0;
        else if (b_ckd[2] && !b_ckd[1]) b_falls <= b_falls + 1;
    end

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic score(input string tag, input bit have, input exp_t e,
                         input logic v, input logic er, input logic [63:0] chv, input int lat);
        if (!have) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected: got valid=%0b frame_err=%0b with no frame expected", tag, v, er);
            return;
        end
        cmp({tag, "_both"}, {63'b0, v & er}, 64'h0);
        cmp({tag, "_kind"}, {63'b0, er}, {63'b0, e.err});
        cmp({tag, "_ch"}, chv, e.data);
        cmp({tag, "_latency"}, 64'(lat), 64'(e.lat));
    endtask

    exp_t a_eq[$], b_eq[$];
    int   a_rise[$], b_rise[$];
    int   a_cnv_hi = 0, a_sck_r = 0;
    logic a_cnv_p = 1'b0, a_sck_p = 1'b0, b_cnv_p = 1'b0;

    always @(negedge clk) begin : mon_a
        exp_t e;
        bit   have;
        int   lat;
        if (!a_rst_n) begin
            a_rise.delete();
            a_cnv_p = 1'b0;
            a_sck_p = 1'b0;
        end else begin
            if (a_valid || a_err) begin
                have = (a_eq.size() != 0);
                e    = '{err: 1'b0, data: 64'h0, lat: 0};
                if (have) e = a_eq.pop_front();
                lat = -1;
                if (a_rise.size() != 0) lat = cyc - a_rise.pop_front();
                score("a", have, e, a_valid, a_err, a_chv, lat);
            end
            if (a_cnv && !a_cnv_p) a_rise.push_back(cyc);
            if (a_cnv) a_cnv_hi++;
            if (a_sck && !a_sck_p) a_sck_r++;
            a_cnv_p = a_cnv;
            a_sck_p = a_sck;
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        bit   have;
        int   lat;
        if (!b_rst_n) begin
            b_rise.delete();
            b_cnv_p = 1'b0;
        end else begin
            if (b_valid || b_err) begin
                have = (b_eq.size() != 0);
                e    = '{err: 1'b0, data: 64'h0, lat: 0};
                if (have) e = b_eq.pop_front();
                lat = -1;
                if (b_rise.size() != 0) lat = cyc - b_rise.pop_front();
                score("b", have, e, b_valid, b_err, b_chv, lat);
            end
            if (b_cnv && !b_cnv_p) b_rise.push_back(cyc);
            b_cnv_p = b_cnv;
        end
    end

    task automatic wait_drain(input bit sel_b, input int budget, input string nm);
        int n = 0;
        while (((sel_b ? b_eq.size() : a_eq.size()) != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((sel_b ? b_eq.size() : a_eq.size()) != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d frames still pending after %0d cycles, required 0",
                     nm, sel_b ? b_eq.size() : a_eq.size(), budget);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int c0, s0, n;
        logic [15:0] k;

        // T1: reset held while inputs toggle
        repeat (10) begin
            @(negedge clk);
            noise_a  = 4'($urandom);
            noise_b  = 4'($urandom);
            noise_ck = 1'($urandom);
            a_en     = 1'($urandom);
            b_en     = 1'($urandom);
        end
        #1;
        cmp("a_rst_cnv", {63'b0, a_cnv}, 64'h0);
        cmp("a_rst_sck", {63'b0, a_sck}, 64'h0);
        cmp("a_rst_valid", {63'b0, a_valid}, 64'h0);
        cmp("a_rst_err", {63'b0, a_err}, 64'h0);
        cmp("a_rst_ch", a_chv, 64'h0);
        cmp("b_rst_cnv", {63'b0, b_cnv}, 64'h0);
        cmp("b_rst_sck", {63'b0, b_sck}, 64'h0);
        cmp("b_rst_valid", {63'b0, b_valid}, 64'h0);
        cmp("b_rst_err", {63'b0, b_err}, 64'h0);
        cmp("b_rst_ch", b_chv, 64'h0);
        @(negedge clk);
        noise_a = '0; noise_b = '0; noise_ck = 1'b0;
        a_en = 1'b0; b_en = 1'b0;
        wait_cycles(3);
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        wait_cycles(20);
        cmp("a_idle_cnv", {63'b0, a_cnv}, 64'h0);
        cmp("a_idle_sck", {63'b0, a_sck}, 64'h0);
        cmp("b_idle_cnv", {63'b0, b_cnv}, 64'h0);
        cmp("b_idle_sck", {63'b0, b_sck}, 64'h0);

        // T2: single internal-mode frame from a one-cycle enable pulse
        a_mq.push_back(64'h8001_7FFE_A5A5_0000);
        a_eq.push_back('{err: 1'b0, data: 64'h8001_7FFE_A5A5_0000, lat: 115});
        c0 = a_cnv_hi; s0 = a_sck_r;
        a_en = 1'b1;
        @(negedge clk);
        a_en = 1'b0;
        wait_drain(1'b0, 300, "t2");
        wait_cycles(20);
        cmp("t2_cnv_cycles", 64'(a_cnv_hi - c0), 64'd2);
        cmp("t2_sck_periods", 64'(a_sck_r - s0), 64'd16);

        // T3: ten back-to-back frames with an incrementing pattern
        for (int i = 0; i < 10; i++) begin
            k = 16'(i);
            a_mq.push_back({16'h1111 * k, 16'hFFFF - k, 16'h8000 + k, 16'h0001 << k});
            a_eq.push_back('{err: 1'b0, data: {16'h1111 * k, 16'hFFFF - k, 16'h8000 + k, 16'h0001 << k}, lat: 115});
        end
        a_en = 1'b1;
        n = 0;
        while (a_eq.size() > 1 && n < 1300) begin
            @(negedge clk);
            n++;
        end
        wait_cycles(10);
        a_en = 1'b0;
        wait_drain(1'b0, 300, "t3");
        wait_cycles(150);

        // T4: CLKOUT mode, full echo
        b_stop_after = 1000;
        b_mq.push_back({4{16'h1234}});
        b_eq.push_back('{err: 1'b0, data: {4{16'h1234}}, lat: 117});
        b_en = 1'b1;
        @(negedge clk);
        b_en = 1'b0;
        wait_drain(1'b1, 300, "t4");
        wait_cycles(20);

        // T5: CLKOUT stops after 10 edges; outputs keep the previous frame
        b_stop_after = 10;
        b_mq.push_back({4{16'h5555}});
        b_eq.push_back('{err: 1'b1, data: {4{16'h1234}}, lat: 127});
        b_en = 1'b1;
        @(negedge clk);
        b_en = 1'b0;
        wait_drain(1'b1, 300, "t5");
        wait_cycles(30);
        cmp("t5_ch_held", b_chv, {4{16'h1234}});

        // T6: reset during SCK period 8, then a clean frame
        a_mq.push_back(64'hDEAD_BEEF_CAFE_F00D);
        a_mq.push_back(64'h0F0F_F0F0_3C3C_C3C3);
        a_eq.push_back('{err: 1'b0, data: 64'h0F0F_F0F0_3C3C_C3C3, lat: 115});
        s0 = a_sck_r;
        a_en = 1'b1;
        n = 0;
        while ((a_sck_r - s0) < 8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        cmp("t6_reach_sck8", 64'(a_sck_r - s0), 64'd8);
        #1 a_rst_n = 1'b0;
        #1;
        cmp("t6_rst_cnv", {63'b0, a_cnv}, 64'h0);
        cmp("t6_rst_sck", {63'b0, a_sck}, 64'h0);
        cmp("t6_rst_valid", {63'b0, a_valid}, 64'h0);
        wait_cycles(3);
        a_rst_n = 1'b1;
        wait_cycles(5);
        a_en = 1'b0;
        wait_drain(1'b0, 300, "t6");
        wait_cycles(150);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
